fp_multiplier_seq: RTL
======================

Name: fp_multiplier_seq

Overview:
- Sequential IEEE-754 single-precision multiplier; the companion (inverse operation) of the divider in the 32-bit FP arithmetic unit.
- Uses a start/busy/done handshake.
- Computes the 24x24 mantissa product iteratively with shift-add, one bit per clock.
- Results feed the same out/exception result path as the divider.

Parameters:
- MANT_W, 24, significand width including hidden bit (fixed for single precision; iteration count = MANT_W).
- BIAS, 127, exponent bias.

Ports:
- control  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  32  multiplicand, IEEE-754 single.
- B  input  32  multiplier, IEEE-754 single.
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high while an operation is in progress (UNPACK, MUL, NORM).
- done  output  1  one-cycle pulse; out/flags valid from this cycle.
- out  output  32  product, IEEE-754 single; held until next done.
- exception  output  1  NaN/Inf input, invalid op, or overflow; held with out.
- underflow  output  1  result flushed to zero by exponent underflow; held with out.

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state=IDLE; out=0, exception=0, underflow=0, busy=0, done=0.
  - Any in-flight operation is discarded.
- States and transitions: IDLE -> UNPACK -> (MUL x24 -> NORM | special) -> DONE -> IDLE.
- IDLE:
  - start=1 at edge k latches A and B, goes to UNPACK, busy=1.
  - start in any other state is ignored; inputs are not re-sampled.
- UNPACK (edge k+1):
  - Decode sign = A[31]^B[31].
  - Exponent 0 is treated as zero (denormals flushed); exponent 255 is Inf/NaN.
  - Special cases go straight to DONE with the result registered:
    - Either operand NaN -> 32'h7FC00000, exception=1.
    - Inf x zero -> 32'h7FC00000, exception=1.
    - Inf x nonzero -> {sign, 8'hFF, 23'h0}, exception=1.
    - Zero x finite -> {sign, 31'h0}, exception=0.
  - Otherwise: load mantissas {1,frac}, clear the 48-bit accumulator, set counter=0, compute the signed 10-bit exponent eA+eB-BIAS, go to MUL.
- MUL (edges k+2..k+25):
  - Each edge: if multiplier LSB=1, add the shifted multiplicand into the 48-bit product; shift; counter++.
  - Leave to NORM after the 24th iteration (counter reaches MANT_W-1 at edge k+25).
- NORM (edge k+26):
  - Product P[47:0]. If P[47]=1: frac=P[46:24], exp+=1. Else: frac=P[45:23].
  - Rounding: truncation (round toward zero); no sticky/round bits.
  - exp>=255 -> {sign, 8'hFF, 23'h0}, exception=1.
  - exp<=0 -> {sign, 31'h0}, underflow=1, exception=0.
  - Else {sign, exp[7:0], frac}, flags 0.
  - Register out and flags; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next edge returns to IDLE.
  - start during DONE is ignored.
  - Earliest new accept is the edge after returning to IDLE.
- Latency from the start-sampling edge k:
  - Normal: done visible after edge k+26.
  - Special: done visible after edge k+2.
- out, exception and underflow change only on entry to DONE or on reset.

Test Plan:
- Reset, A=3FC00000 (1.5), B=40400000 (3.0), start 1 cycle -> busy for 26 cycles, then done pulse; out=40900000, exception=0, underflow=0.
- A=C0900000 (-4.5), B=3FC00000 (1.5) -> out=C0D80000 (-6.75), normal latency; a second start pulse while busy is ignored (exactly one done).
- A=00000000, B=C0400000 (-3.0) -> out=80000000, exception=0, done 2 cycles after start; A=7F800000, B=00000000 -> out=7FC00000, exception=1.
- A=7F000000, B=7F000000 -> out=7F800000, exception=1; A=00800000, B=00800000 -> out=00000000, underflow=1.
- Assert reset=0 mid-MUL (about 10 cycles after start) -> out/flags/busy/done zero immediately, no done pulse; after release, a new 1.5x3.0 gives 40900000.

Source files
------------

// File: rtl/fp_multiplier_seq.sv
// fp_multiplier_seq
// Sequential IEEE-754 single-precision multiplier. It forms the 24x24
// significand product with shift-add, one bit per clock. Denormal inputs are
// flushed to zero and the result is truncated (round toward zero).
//
// Ports
//   control   : clock, rising edge
//   reset     : asynchronous active-low reset
//   A, B      : operands, IEEE-754 single (latched when start is accepted)
//   start     : request, sampled only while idle
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse; out and flags are valid from this cycle
//   out       : product, held until the next done
//   exception : NaN/Inf input, invalid operation or overflow
//   underflow : result flushed to zero by exponent underflow
module fp_multiplier_seq #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic        control,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        exception,
  output logic        underflow
);

  localparam int PW    = 2 * MANT_W;
  localparam int FW    = MANT_W - 1;
  localparam int CNT_W = $clog2(MANT_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              sign_q, sign_d;
  logic [9:0]        exp_q, exp_d;        // two's complement, biased exponent
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              special_q, special_d;
  logic [31:0]       spec_out_q, spec_out_d;
  logic              spec_exc_q, spec_exc_d;
  logic [31:0]       out_q, out_d;
  logic              exc_q, exc_d;
  logic              unf_q, unf_d;

  // Operand decode, used in UNPACK
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_w;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign sign_w = a_q[31] ^ b_q[31];

  // Normalisation temporaries, used in NORM
  logic [FW-1:0] norm_frac;
  logic [9:0]    norm_exp;

  // State register
  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      // Special operands skip the multiply but still pass through NORM, so
      // out only changes on entry to DONE and the latency is two edges.
      S_UNPACK: state_d = (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero)
                          ? S_NORM : S_MUL;
      S_MUL:    if (cnt_q == CNT_W'(MANT_W - 1)) state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_UNPACK) || (state_q == S_MUL) || (state_q == S_NORM);
    done = (state_q == S_DONE);
  end

  assign out       = out_q;
  assign exception = exc_q;
  assign underflow = unf_q;

  // Datapath next values
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    special_d  = special_q;
    spec_out_d = spec_out_q;
    spec_exc_d = spec_exc_q;
    out_d      = out_q;
    exc_d      = exc_q;
    unf_d      = unf_q;
    norm_frac  = '0;
    norm_exp   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d = A;
          b_d = B;
        end
      end

      S_UNPACK: begin
        sign_d    = sign_w;
        special_d = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
        if (a_nan || b_nan) begin
          spec_out_d = 32'h7FC0_0000;
          spec_exc_d = 1'b1;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          spec_out_d = 32'h7FC0_0000;
          spec_exc_d = 1'b1;
        end else if (a_inf || b_inf) begin
          spec_out_d = {sign_w, 8'hFF, 23'h0};
          spec_exc_d = 1'b1;
        end else begin
          spec_out_d = {sign_w, 31'h0};
          spec_exc_d = 1'b0;
        end
        mcand_d  = {{(PW - MANT_W){1'b0}}, 1'b1, fa};
        mplier_d = {1'b1, fb};
        prod_d   = '0;
        cnt_d    = '0;
        exp_d    = {2'b00, ea} + {2'b00, eb} - 10'(BIAS);
      end

      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end

      S_NORM: begin
        if (special_q) begin
          out_d = spec_out_q;
          exc_d = spec_exc_q;
          unf_d = 1'b0;
        end else begin
          // Product of two [1,2) significands lies in [1,4): at most one
          // position of normalisation is ever needed.
          if (prod_q[PW-1]) begin
            norm_frac = prod_q[PW-2 -: FW];
            norm_exp  = exp_q + 10'd1;
          end else begin
            norm_frac = prod_q[PW-3 -: FW];
            norm_exp  = exp_q;
          end
          if ($signed(norm_exp) >= 10'sd255) begin
            out_d = {sign_q, 8'hFF, 23'h0};
            exc_d = 1'b1;
            unf_d = 1'b0;
          end else if ($signed(norm_exp) <= 10'sd0) begin
            out_d = {sign_q, 31'h0};
            exc_d = 1'b0;
            unf_d = 1'b1;
          end else begin
            out_d = {sign_q, norm_exp[7:0], norm_frac};
            exc_d = 1'b0;
            unf_d = 1'b0;
          end
        end
      end

      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
      spec_out_q <= '0;
      spec_exc_q <= 1'b0;
      out_q      <= '0;
      exc_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      special_q  <= special_d;
      spec_out_q <= spec_out_d;
      spec_exc_q <= spec_exc_d;
      out_q      <= out_d;
      exc_q      <= exc_d;
      unf_q      <= unf_d;
    end
  end

endmodule
